mult_div_unit: RTL and testbench

Execute-stage multiply/divide unit of the P7 pipelined MIPS core. It consumes the `start`/`MDop` pair decoded by the controller, together with the forwarded rs/rt operands of the E-stage instruction. It owns the HI/LO registers and holds `busy` for the fixed operation latency. The hazard unit stalls any `useMD` instruction in D while `start` or `busy` is high. `mfhi`/`mflo` read `HI`/`LO` directly.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 110 +++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Bus between the E-stage controller/forwarding logic and the multiply/divide unit.
// The controller drives the request side. The unit returns busy, the architectural HI/LO and its cycle counter.
interface mult_div_unit_if;
  // Handshake: start is a one-cycle request qualified by MDop/A/B.
  // It is taken only when busy is low or completes that cycle, and only when req is low.
  // There is no ready: the hazard unit must hold back any MD instruction while start or busy is high.
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [3:0]  dbg_cnt;

  modport master (
    output start, MDop, A, B, req,
    input  busy, HI, LO, dbg_cnt
  );

  modport slave (
    input  start, MDop, A, B, req,
    output busy, HI, LO, dbg_cnt
  );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and runs fixed-latency mult (5) and div (10) operations.
// The result is computed at accept, held in temporaries, and committed when the down-counter reaches zero.
module mult_div_unit (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave md
);
  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic        slot_free, accept_md, accept_mt;
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod;
  logic        is_sdiv;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quo, rem;

  // A new op may start on the same edge the previous one completes.
  assign slot_free = (cnt_q <= 4'd1);
  assign accept_md = md.start && slot_free && !md.req && !md.MDop[2];
  assign accept_mt = !md.start && slot_free && !md.req &&
                     ((md.MDop == OP_MTHI) || (md.MDop == OP_MTLO));

  // Sign/zero extension to 64 bits lets one unsigned multiplier serve both mult and multu.
  assign a_sx = {{32{md.A[31]}}, md.A};
  assign b_sx = {{32{md.B[31]}}, md.B};
  assign a_zx = {32'd0, md.A};
  assign b_zx = {32'd0, md.B};
  assign prod = (md.MDop == OP_MULT) ? (a_sx * b_sx) : (a_zx * b_zx);

  // Signed divide works on magnitudes; 0x80000000 keeps its magnitude as an unsigned value.
  assign is_sdiv  = (md.MDop == OP_DIV);
  assign num      = (is_sdiv && md.A[31]) ? (32'd0 - md.A) : md.A;
  assign den      = (is_sdiv && md.B[31]) ? (32'd0 - md.B) : md.B;
  assign den_safe = (den == 32'd0) ? 32'd1 : den;
  assign q_mag    = num / den_safe;
  assign r_mag    = num % den_safe;
  assign quo      = (is_sdiv && (md.A[31] ^ md.B[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem      = (is_sdiv && md.A[31]) ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    // A divide by zero still occupies the unit but leaves HI/LO untouched.
    if ((cnt_q == 4'd1) && commit_q) begin
      hi_d = hi_tmp_q;
      lo_d = lo_tmp_q;
    end
    if (accept_md) begin
      if (md.MDop == OP_MULT || md.MDop == OP_MULTU) begin
        cnt_d    = MULT_CYC;
        hi_tmp_d = prod[63:32];
        lo_tmp_d = prod[31:0];
        commit_d = 1'b1;
      end else begin
        cnt_d    = DIV_CYC;
        hi_tmp_d = rem;
        lo_tmp_d = quo;
        commit_d = (md.B != 32'd0);
      end
    end
    // An mt landing on a completion edge wins over the completing result.
    if (accept_mt) begin
      if (md.MDop == OP_MTHI) hi_d = md.A;
      else                    lo_d = md.A;
    end
    busy_d = (cnt_d != 4'd0);
  end

  always_comb begin
    md.busy    = busy_q;
    md.HI      = hi_q;
    md.LO      = lo_q;
    md.dbg_cnt = cnt_q;
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO pairs are queued at issue and compared at completion.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if md_if ();
  mult_div_unit dut (.clk(clk), .reset(reset), .md(md_if.slave));

  logic [63:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {md_if.HI, md_if.LO}, e);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start = 1'b1;
    md_if.MDop  = op;
    md_if.A     = a;
    md_if.B     = b;
    tick();
    md_if.start = 1'b0;
    md_if.MDop  = 3'd7;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    md_if.start = 1'b0;
    md_if.MDop  = op;
    md_if.A     = a;
    tick();
    md_if.MDop  = 3'd7;
  endtask

  task automatic busy_len(output int len);
    len = 0;
    while (md_if.busy === 1'b1 && len < 40) begin
      len++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rp;
    reset        = 1'b0;
    md_if.start  = 1'b0;
    md_if.MDop   = 3'd7;
    md_if.A      = 32'd0;
    md_if.B      = 32'd0;
    md_if.req    = 1'b0;
    repeat (3) tick();
    check("reset_busy", {63'd0, md_if.busy}, 64'd0);
    check("reset_hilo", {md_if.HI, md_if.LO}, 64'd0);
    reset = 1'b1;
    tick();
    check("idle_busy", {63'd0, md_if.busy}, 64'd0);

    // mult -2 * 3
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    busy_len(n);
    check("mult_busy_len", 64'(n), 64'd5);
    check_result("mult_result");

    // multu max * max
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    busy_len(n);
    check("multu_busy_len", 64'(n), 64'd5);
    check_result("multu_result");

    // div -7 / 2
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    busy_len(n);
    check("div_busy_len", 64'(n), 64'd10);
    check_result("div_result");

    // divu same operands
    exp_q.push_back({32'h00000001, 32'h7FFFFFFC});
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    busy_len(n);
    check("divu_busy_len", 64'(n), 64'd10);
    check_result("divu_result");

    // signed overflow corner
    exp_q.push_back({32'h00000000, 32'h80000000});
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    busy_len(n);
    check_result("div_ovf_result");

    // divide by zero keeps HI/LO
    mt(3'd4, 32'd1);
    mt(3'd5, 32'd2);
    check("mt_setup", {md_if.HI, md_if.LO}, {32'd1, 32'd2});
    exp_q.push_back({32'd1, 32'd2});
    issue(3'd2, 32'd1234, 32'd0);
    busy_len(n);
    check("div0_busy_len", 64'(n), 64'd10);
    check_result("div0_result");

    // mthi
    mt(3'd4, 32'h12345678);
    check("mthi_hi", {32'd0, md_if.HI}, {32'd0, 32'h12345678});
    check("mthi_busy", {63'd0, md_if.busy}, 64'd0);

    // mult squashed by req
    md_if.req = 1'b1;
    issue(3'd0, 32'd5, 32'd5);
    md_if.req = 1'b0;
    check("squash_busy", {63'd0, md_if.busy}, 64'd0);
    tick();
    check("squash_hilo", {md_if.HI, md_if.LO}, {32'h12345678, 32'd2});

    // req pulse mid-divide does not abort
    exp_q.push_back({32'd2, 32'd14});
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    md_if.req = 1'b1;
    tick();
    md_if.req = 1'b0;
    busy_len(n);
    check("reqmid_busy_len", 64'(n + 3), 64'd10);
    check_result("reqmid_result");

    // reset mid-divide
    issue(3'd3, 32'd999, 32'd5);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rstmid_busy", {63'd0, md_if.busy}, 64'd0);
    check("rstmid_hilo", {md_if.HI, md_if.LO}, 64'd0);
    check("rstmid_cnt", {60'd0, md_if.dbg_cnt}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // back-to-back: mult then divu started at the completion edge
    exp_q.push_back({32'd0, 32'd42});
    exp_q.push_back({32'd1, 32'd333});
    issue(3'd0, 32'd7, 32'd6);
    repeat (4) tick();
    check("b2b_busy_before", {63'd0, md_if.busy}, 64'd1);
    issue(3'd3, 32'd1000, 32'd3);
    check_result("b2b_first_result");
    busy_len(n);
    check("b2b_second_busy_len", 64'(n), 64'd10);
    check_result("b2b_second_result");

    // random multu / divu
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rb = $urandom_range(1, 32'hFFFF);
      rp = {32'd0, ra} * {32'd0, rb};
      exp_q.push_back(rp);
      issue(3'd1, ra, rb);
      busy_len(n);
      check("rand_multu", {md_if.HI, md_if.LO}, exp_q.pop_front());
      exp_q.push_back({ra % rb, ra / rb});
      issue(3'd3, ra, rb);
      busy_len(n);
      check("rand_divu", {md_if.HI, md_if.LO}, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
